mem_stage: RTL and testbench

Memory-access pipeline stage of the RISC-V core. It consumes the EX/MEM latch outputs (destination register, write enable, ALU result, memory op, store data) and turns loads and stores into byte-serial transactions on the shared 8-bit RAM port. It stalls the pipeline for the duration of each access and delivers writeback data to the MEM/WB latch. Its outputs are also the MEM-stage forwarding source for EX.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_load_ext.sv | 24 ++
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage constants: bus widths, memory-op encodings, FSM state
// encodings, the IO address-decode tag and small op-decode helpers.
package mem_stage_pkg;

   localparam int MEM_OP_W   = 4;
   localparam int REG_ADDR_W = 5;
   localparam int REG_W      = 32;
   localparam int ADDR_W     = 32;

   localparam logic [MEM_OP_W-1:0] MEM_NONE = 4'd0;
   localparam logic [MEM_OP_W-1:0] MEM_LB   = 4'd1;
   localparam logic [MEM_OP_W-1:0] MEM_LH   = 4'd2;
   localparam logic [MEM_OP_W-1:0] MEM_LW   = 4'd3;
   localparam logic [MEM_OP_W-1:0] MEM_LBU  = 4'd4;
   localparam logic [MEM_OP_W-1:0] MEM_LHU  = 4'd5;
   localparam logic [MEM_OP_W-1:0] MEM_SB   = 4'd6;
   localparam logic [MEM_OP_W-1:0] MEM_SH   = 4'd7;
   localparam logic [MEM_OP_W-1:0] MEM_SW   = 4'd8;

   // Address bits [17:16] equal to this tag select the IO region.
   localparam logic [1:0] IO_ADDR_TAG = 2'b11;

   typedef enum logic [1:0] {
      MEM_IDLE   = 2'd0,
      MEM_ACCESS = 2'd1,
      MEM_WAIT   = 2'd2,
      MEM_DONE   = 2'd3
   } mem_state_e;

   function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
         default:                                  is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
         default:                is_store = 1'b0;
      endcase
   endfunction

   // Index of the final byte of the access (byte count minus one).
   function automatic logic [1:0] last_byte(input logic [MEM_OP_W-1:0] op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: last_byte = 2'd1;
         MEM_LW, MEM_SW:          last_byte = 2'd3;
         default:                 last_byte = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result assembly: sign/zero extension of the captured little-endian
// bytes according to the memory op.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [MEM_OP_W-1:0] memop_i,
   input  logic [REG_W-1:0]    data_i,
   output logic [REG_W-1:0]    result_o
);

   // Select width and extension from the op.
   always_comb begin
      result_o = data_i;
      case (memop_i)
         MEM_LB:  result_o = {{24{data_i[7]}}, data_i[7:0]};
         MEM_LH:  result_o = {{16{data_i[15]}}, data_i[15:0]};
         MEM_LBU: result_o = {24'd0, data_i[7:0]};
         MEM_LHU: result_o = {16'd0, data_i[15:0]};
         MEM_LW:  result_o = data_i;
         default: result_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores on the shared 8-bit RAM port.
// Optional MEM_IO_STALL_EN holds IO-region stores while io_full is high.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MEM_OP_W-1:0]   memop_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [REG_W-1:0]      wdata_i,
   input  logic [REG_W-1:0]      sdata_i,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [ADDR_W-1:0]     mem_a,
   output logic [7:0]            mem_dout,
   output logic                  mem_wr,
   input  logic [7:0]            mem_din,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [REG_W-1:0]      wdata_o,
   output logic                  mem_stall
`ifdef MEM_IO_STALL_EN
   ,
   input  logic                  io_full
`endif
);

   mem_state_e        state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [REG_W-1:0]  data_q, data_d;
   logic [REG_W-1:0]  load_ext_s;
   logic [ADDR_W-1:0] addr_s;
   logic [1:0]        last_k_s;
   logic [1:0]        cap_k_s;
   logic              ld_s;
   logic              st_s;
   logic              io_block_s;
   logic              issue_s;

   assign ld_s     = is_load(memop_i);
   assign st_s     = is_store(memop_i);
   assign last_k_s = last_byte(memop_i);
   assign addr_s   = wdata_i + {30'd0, k_q};
   // The byte issued last cycle is k-1; it wraps to 3 after the fourth issue.
   assign cap_k_s  = k_q - 2'd1;

`ifdef MEM_IO_STALL_EN
   assign io_block_s = st_s && (wdata_i[17:16] == IO_ADDR_TAG) && io_full;
`else
   assign io_block_s = 1'b0;
`endif

   mem_load_ext u_load_ext (
      .memop_i  (memop_i),
      .data_i   (data_q),
      .result_o (load_ext_s)
   );

   // State, byte counter and captured load data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         k_q     <= 2'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         data_q  <= data_d;
      end
   end

   // Next-state, capture and port drive.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      data_d    = data_q;
      issue_s   = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_a     = 32'd0;
      mem_dout  = 8'd0;
      mem_stall = 1'b0;
      wd_o      = wd_i;
      wreg_o    = 1'b0;
      wdata_o   = wdata_i;
      if (rst) begin
         // Outputs sit at reset values for as long as reset is asserted.
         wd_o    = 5'd0;
         wdata_o = 32'd0;
      end else begin
         case (state_q)
            MEM_IDLE: begin
               if (memop_i == MEM_NONE) begin
                  wreg_o = wreg_i;
               end else if (io_block_s) begin
                  mem_stall = 1'b1;
               end else begin
                  mem_req   = 1'b1;
                  mem_stall = 1'b1;
                  if (mem_gnt) begin
                     issue_s = 1'b1;
                     k_d     = 2'd1;
                     if (last_k_s == 2'd0) begin
                        state_d = ld_s ? MEM_WAIT : MEM_DONE;
                     end else begin
                        state_d = MEM_ACCESS;
                     end
                  end else begin
                     state_d = MEM_IDLE;
                  end
               end
            end
            MEM_ACCESS: begin
               mem_req   = 1'b1;
               mem_stall = 1'b1;
               issue_s   = 1'b1;
               k_d       = k_q + 2'd1;
               if (ld_s) begin
                  data_d[{cap_k_s, 3'b000} +: 8] = mem_din;
               end else begin
                  data_d = data_q;
               end
               if (k_q == last_k_s) begin
                  state_d = ld_s ? MEM_WAIT : MEM_DONE;
               end else begin
                  state_d = MEM_ACCESS;
               end
            end
            MEM_WAIT: begin
               mem_stall = 1'b1;
               data_d[{cap_k_s, 3'b000} +: 8] = mem_din;
               state_d = MEM_DONE;
            end
            MEM_DONE: begin
               wreg_o  = wreg_i;
               wdata_o = ld_s ? load_ext_s : wdata_i;
               k_d     = 2'd0;
               state_d = MEM_IDLE;
            end
            default: begin
               k_d     = 2'd0;
               state_d = MEM_IDLE;
            end
         endcase
         if (issue_s) begin
            mem_a    = addr_s;
            mem_wr   = st_s;
            mem_dout = st_s ? sdata_i[{k_q, 3'b000} +: 8] : 8'd0;
         end else begin
            mem_a    = 32'd0;
            mem_wr   = 1'b0;
            mem_dout = 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte RAM model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  memop_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] sdata_i;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        mem_stall;
`ifdef MEM_IO_STALL_EN
   logic        io_full;
`endif

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   logic [7:0] wmem [logic [31:0]];

   mem_stage dut (
      .clk(clk), .rst(rst), .memop_i(memop_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .wdata_i(wdata_i), .sdata_i(sdata_i), .mem_req(mem_req), .mem_gnt(mem_gnt),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .mem_stall(mem_stall)
`ifdef MEM_IO_STALL_EN
      , .io_full(io_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: init_byte = 8'h11;
         32'h0000_0101: init_byte = 8'h22;
         32'h0000_0102: init_byte = 8'h33;
         32'h0000_0103: init_byte = 8'h44;
         32'h0000_0200: init_byte = 8'h80;
         32'hFFFF_FFFE: init_byte = 8'hA1;
         32'hFFFF_FFFF: init_byte = 8'hB2;
         32'h0000_0000: init_byte = 8'hC3;
         32'h0000_0001: init_byte = 8'hD4;
         default:       init_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      ram_rd = wmem.exists(a) ? wmem[a] : init_byte(a);
   endfunction

   // RAM: read data returns one cycle after the address, writes on mem_wr.
   always @(posedge clk) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr === 1'b1) begin
         wmem[mem_a] = mem_dout;
         wr_count++;
      end
   end

   task automatic drive(input logic [3:0] op, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] sdata);
      memop_i = op; wd_i = wd; wreg_i = wr; wdata_i = wdata; sdata_i = sdata;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_gnt = 1'b0;
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", mem_wr); end
      checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", mem_a); end
      checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", mem_dout); end
      checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got=%b exp=0", wreg_o); end
      checks++; if (wd_o !== 5'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd_o); end
      checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      @(posedge clk); #1;
      drive(MEM_NONE, 5'd7, 1'b1, 32'h1234_5678, 32'd0);
      #1;
      checks++; if (wd_o !== 5'd7) begin errors++; $display("FAIL pass_wd got=%h exp=07", wd_o); end
      checks++; if (wreg_o !== 1'b1) begin errors++; $display("FAIL pass_wreg got=%b exp=1", wreg_o); end
      checks++; if (wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL pass_wdata got=%h exp=12345678", wdata_o); end
      checks++; if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b/%b exp=0/0", mem_stall, mem_req); end
   endtask

   task automatic test_lw();
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      drive(MEM_LW, 5'd3, 1'b1, 32'h0000_0100, 32'd0);
      for (int c = 0; c <= 5; c++) begin
         #1;
         checks++; if (mem_stall !== (c <= 4)) begin errors++; $display("FAIL lw_stall c=%0d got=%b exp=%b", c, mem_stall, (c <= 4)); end
         checks++; if (mem_req !== (c <= 3)) begin errors++; $display("FAIL lw_req c=%0d got=%b exp=%b", c, mem_req, (c <= 3)); end
         checks++; if (wreg_o !== (c == 5)) begin errors++; $display("FAIL lw_wreg c=%0d got=%b exp=%b", c, wreg_o, (c == 5)); end
         if (c <= 3) begin
            checks++; if (mem_a !== 32'h100 + 32'(c)) begin errors++; $display("FAIL lw_addr c=%0d got=%h exp=%h", c, mem_a, 32'h100 + 32'(c)); end
         end else begin
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL lw_wr c=%0d got=%b exp=0", c, mem_wr); end
         end
         if (c == 5) begin
            checks++; if (wdata_o !== 32'h4433_2211) begin errors++; $display("FAIL lw_data got=%h exp=44332211", wdata_o); end
            checks++; if (wd_o !== 5'd3) begin errors++; $display("FAIL lw_wd got=%h exp=03", wd_o); end
         end
         @(posedge clk); #1;
      end
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic test_lb_lbu();
      logic [3:0]  ops [2];
      logic [31:0] exps [2];
      ops[0] = MEM_LB;  exps[0] = 32'hFFFF_FF80;
      ops[1] = MEM_LBU; exps[1] = 32'h0000_0080;
      for (int t = 0; t < 2; t++) begin
         @(posedge clk); #1;
         drive(ops[t], 5'd4, 1'b1, 32'h0000_0200, 32'd0);
         for (int c = 0; c <= 2; c++) begin
            #1;
            checks++; if (mem_stall !== (c <= 1)) begin errors++; $display("FAIL lb_stall t=%0d c=%0d got=%b exp=%b", t, c, mem_stall, (c <= 1)); end
            if (c == 2) begin
               checks++; if (wdata_o !== exps[t]) begin errors++; $display("FAIL lb_data t=%0d got=%h exp=%h", t, wdata_o, exps[t]); end
               checks++; if (wreg_o !== 1'b1) begin errors++; $display("FAIL lb_wreg t=%0d got=%b exp=1", t, wreg_o); end
            end
            @(posedge clk); #1;
         end
         drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
      end
   endtask

   task automatic test_sh();
      int w0;
      w0 = wr_count;
      @(posedge clk); #1;
      drive(MEM_SH, 5'd0, 1'b0, 32'h0000_0301, 32'hABCD_1234);
      for (int c = 0; c <= 2; c++) begin
         #1;
         checks++; if (mem_wr !== (c <= 1)) begin errors++; $display("FAIL sh_wr c=%0d got=%b exp=%b", c, mem_wr, (c <= 1)); end
         checks++; if (mem_stall !== (c <= 1)) begin errors++; $display("FAIL sh_stall c=%0d got=%b exp=%b", c, mem_stall, (c <= 1)); end
         if (c == 0) begin
            checks++; if (mem_a !== 32'h301 || mem_dout !== 8'h34) begin errors++; $display("FAIL sh_b0 got=%h/%h exp=301/34", mem_a, mem_dout); end
         end else if (c == 1) begin
            checks++; if (mem_a !== 32'h302 || mem_dout !== 8'h12) begin errors++; $display("FAIL sh_b1 got=%h/%h exp=302/12", mem_a, mem_dout); end
         end else begin
            checks++; if (wdata_o !== 32'h301 || wreg_o !== 1'b0) begin errors++; $display("FAIL sh_done got=%h/%b exp=301/0", wdata_o, wreg_o); end
         end
         @(posedge clk); #1;
      end
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
      checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL sh_count got=%0d exp=2", wr_count - w0); end
      checks++; if (ram_rd(32'h301) !== 8'h34 || ram_rd(32'h302) !== 8'h12) begin errors++; $display("FAIL sh_ram got=%h/%h exp=34/12", ram_rd(32'h301), ram_rd(32'h302)); end
   endtask

   task automatic test_wrap_nogrant();
      logic [31:0] ea;
      @(posedge clk); #1;
      drive(MEM_LW, 5'd5, 1'b1, 32'hFFFF_FFFE, 32'd0);
      for (int c = 0; c <= 8; c++) begin
         mem_gnt = (c >= 3);
         #1;
         checks++; if (mem_stall !== (c <= 7)) begin errors++; $display("FAIL wrap_stall c=%0d got=%b exp=%b", c, mem_stall, (c <= 7)); end
         checks++; if (mem_req !== (c <= 6)) begin errors++; $display("FAIL wrap_req c=%0d got=%b exp=%b", c, mem_req, (c <= 6)); end
         if (c >= 3 && c <= 6) begin
            ea = 32'hFFFF_FFFE + 32'(c - 3);
            checks++; if (mem_a !== ea) begin errors++; $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, mem_a, ea); end
         end
         if (c == 8) begin
            checks++; if (wdata_o !== 32'hD4C3_B2A1 || wreg_o !== 1'b1) begin errors++; $display("FAIL wrap_data got=%h/%b exp=d4c3b2a1/1", wdata_o, wreg_o); end
         end
         @(posedge clk); #1;
      end
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic test_reset_mid_sw();
      int w0;
      w0 = wr_count;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      drive(MEM_SW, 5'd0, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
      for (int c = 0; c <= 1; c++) begin
         #1;
         checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rsw_wr c=%0d got=%b exp=1", c, mem_wr); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rsw_wr_drop got=%b exp=0", mem_wr); end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
      #1;
      checks++; if ({mem_req, mem_wr, mem_stall, wreg_o} !== 4'b0000) begin errors++; $display("FAIL rsw_ctl got=%b exp=0000", {mem_req, mem_wr, mem_stall, wreg_o}); end
      checks++; if (mem_a !== 32'd0 || mem_dout !== 8'd0 || wdata_o !== 32'd0 || wd_o !== 5'd0) begin errors++; $display("FAIL rsw_data got=%h/%h/%h/%h exp=0", mem_a, mem_dout, wdata_o, wd_o); end
      @(posedge clk); #1;
      drive(MEM_NONE, 5'd9, 1'b1, 32'h0000_0055, 32'd0);
      #1;
      checks++; if (mem_stall !== 1'b0 || wreg_o !== 1'b1 || wdata_o !== 32'h55 || wd_o !== 5'd9) begin errors++; $display("FAIL rsw_add got=%b/%b/%h/%h exp=0/1/55/09", mem_stall, wreg_o, wdata_o, wd_o); end
      checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL rsw_count got=%0d exp=2", wr_count - w0); end
      checks++; if (ram_rd(32'h400) !== 8'hEF || ram_rd(32'h401) !== 8'hBE || wmem.exists(32'h402)) begin errors++; $display("FAIL rsw_ram got=%h/%h exp=ef/be", ram_rd(32'h400), ram_rd(32'h401)); end
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic test_io_region();
`ifdef MEM_IO_STALL_EN
      io_full = 1'b1;
      @(posedge clk); #1;
      drive(MEM_SB, 5'd0, 1'b0, 32'h0003_0000, 32'h0000_005A);
      for (int c = 0; c <= 5; c++) begin
         io_full = (c <= 3);
         #1;
         checks++; if (mem_req !== (c == 4)) begin errors++; $display("FAIL io_req c=%0d got=%b exp=%b", c, mem_req, (c == 4)); end
         checks++; if (mem_wr !== (c == 4)) begin errors++; $display("FAIL io_wr c=%0d got=%b exp=%b", c, mem_wr, (c == 4)); end
         checks++; if (mem_stall !== (c <= 4)) begin errors++; $display("FAIL io_stall c=%0d got=%b exp=%b", c, mem_stall, (c <= 4)); end
         if (c == 4) begin
            checks++; if (mem_a !== 32'h3_0000 || mem_dout !== 8'h5A) begin errors++; $display("FAIL io_byte got=%h/%h exp=30000/5a", mem_a, mem_dout); end
         end
         @(posedge clk); #1;
      end
`else
      @(posedge clk); #1;
      drive(MEM_SB, 5'd0, 1'b0, 32'h0003_0000, 32'h0000_005A);
      for (int c = 0; c <= 1; c++) begin
         #1;
         checks++; if (mem_wr !== (c == 0)) begin errors++; $display("FAIL io_wr c=%0d got=%b exp=%b", c, mem_wr, (c == 0)); end
         checks++; if (mem_stall !== (c == 0)) begin errors++; $display("FAIL io_stall c=%0d got=%b exp=%b", c, mem_stall, (c == 0)); end
         if (c == 0) begin
            checks++; if (mem_a !== 32'h3_0000 || mem_dout !== 8'h5A) begin errors++; $display("FAIL io_byte got=%h/%h exp=30000/5a", mem_a, mem_dout); end
         end
         @(posedge clk); #1;
      end
`endif
      drive(MEM_NONE, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
`ifdef MEM_IO_STALL_EN
      io_full = 1'b0;
`endif
      test_reset();
      test_passthrough();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_wrap_nogrant();
      test_reset_mid_sw();
      test_io_region();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
